// File: rtl/axi_mem_arbiter_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter.
// Grant encodings, widths and FSM state type.
package axi_mem_arbiter_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int ACERR_WIDTH     = 2;
  localparam int NUM_ARB_MASTERS = 2;

  localparam logic [1:0] NO_GRANT      = 2'b00;
  localparam logic [1:0] INSTMEM_GRANT = 2'b01;
  localparam logic [1:0] DATAMEM_GRANT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    LS_I = 1'b0,
    LS_D = 1'b1
  } last_t;

endpackage

// File: rtl/axi_mem_arbiter_grant_mux.sv
// Combinational channel steering between the granted master
// and the slave port; everything ungranted is held at zero.
import axi_mem_arbiter_pkg::*;

module axi_grant_mux #(
  parameter int DW = DATA_WIDTH
) (
  input  logic [1:0]    grant,
  input  logic [DW-1:0] i_araddr,
  input  logic          i_arvalid,
  input  logic          i_rready,
  output logic          i_arready,
  output logic          i_rvalid,
  input  logic [DW-1:0] d_araddr,
  input  logic          d_arvalid,
  input  logic          d_rready,
  input  logic [DW-1:0] d_awaddr,
  input  logic          d_awvalid,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_wstrb,
  input  logic          d_wvalid,
  input  logic          d_bready,
  output logic          d_arready,
  output logic          d_rvalid,
  output logic          d_awready,
  output logic          d_wready,
  output logic          d_bvalid,
  output logic [DW-1:0] s_araddr,
  output logic          s_arvalid,
  input  logic          s_arready,
  input  logic          s_rvalid,
  output logic          s_rready,
  output logic [DW-1:0] s_awaddr,
  output logic          s_awvalid,
  input  logic          s_awready,
  output logic [DW-1:0] s_wdata,
  output logic [3:0]    s_wstrb,
  output logic          s_wvalid,
  input  logic          s_wready,
  input  logic          s_bvalid,
  output logic          s_bready
);

  always_comb begin
    i_arready = 1'b0;
    i_rvalid  = 1'b0;
    d_arready = 1'b0;
    d_rvalid  = 1'b0;
    d_awready = 1'b0;
    d_wready  = 1'b0;
    d_bvalid  = 1'b0;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    case (grant)
      INSTMEM_GRANT: begin
        s_araddr  = i_araddr;
        s_arvalid = i_arvalid;
        s_rready  = i_rready;
        i_arready = s_arready;
        i_rvalid  = s_rvalid;
      end
      DATAMEM_GRANT: begin
        s_araddr  = d_araddr;
        s_arvalid = d_arvalid;
        s_rready  = d_rready;
        s_awaddr  = d_awaddr;
        s_awvalid = d_awvalid;
        s_wdata   = d_wdata;
        s_wstrb   = d_wstrb;
        s_wvalid  = d_wvalid;
        s_bready  = d_bready;
        d_arready = s_arready;
        d_rvalid  = s_rvalid;
        d_awready = s_awready;
        d_wready  = s_wready;
        d_bvalid  = s_bvalid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the shared AXI4-Lite memory port.
// Grant is held from first request until the owning transaction completes.
import axi_mem_arbiter_pkg::*;

module axi_mem_arbiter #(
  parameter int DATA_WIDTH  = axi_mem_arbiter_pkg::DATA_WIDTH,
  parameter int ACERR_WIDTH = axi_mem_arbiter_pkg::ACERR_WIDTH,
  parameter int GRANT_W     = NUM_ARB_MASTERS
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   Irequest,
  input  logic                   Drequest,
  output logic [GRANT_W-1:0]     grant,
  input  logic [DATA_WIDTH-1:0]  i_araddr,
  input  logic                   i_arvalid,
  input  logic                   i_rready,
  output logic                   i_arready,
  output logic                   i_rvalid,
  input  logic [DATA_WIDTH-1:0]  d_araddr,
  input  logic                   d_arvalid,
  input  logic                   d_rready,
  input  logic [DATA_WIDTH-1:0]  d_awaddr,
  input  logic                   d_awvalid,
  input  logic [DATA_WIDTH-1:0]  d_wdata,
  input  logic [3:0]             d_wstrb,
  input  logic                   d_wvalid,
  input  logic                   d_bready,
  output logic                   d_arready,
  output logic                   d_rvalid,
  output logic                   d_awready,
  output logic                   d_wready,
  output logic                   d_bvalid,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic [ACERR_WIDTH-1:0] rresp,
  output logic [ACERR_WIDTH-1:0] bresp,
  output logic [DATA_WIDTH-1:0]  s_araddr,
  output logic                   s_arvalid,
  input  logic                   s_arready,
  input  logic [DATA_WIDTH-1:0]  s_rdata,
  input  logic [ACERR_WIDTH-1:0] s_rresp,
  input  logic                   s_rvalid,
  output logic                   s_rready,
  output logic [DATA_WIDTH-1:0]  s_awaddr,
  output logic                   s_awvalid,
  input  logic                   s_awready,
  output logic [DATA_WIDTH-1:0]  s_wdata,
  output logic [3:0]             s_wstrb,
  output logic                   s_wvalid,
  input  logic                   s_wready,
  input  logic [ACERR_WIDTH-1:0] s_bresp,
  input  logic                   s_bvalid,
  output logic                   s_bready
);

  arb_state_t         r_state;
  last_t              r_last;
  logic               r_d_wr;
  logic [GRANT_W-1:0] r_grant;

  logic w_r_hs;
  logic w_b_hs;
  logic w_aw_hs;
  logic w_d_done;
  logic w_pick_i;

  assign w_r_hs   = s_rvalid & s_rready;
  assign w_b_hs   = s_bvalid & s_bready;
  assign w_aw_hs  = s_awvalid & s_awready;
  assign w_d_done = r_d_wr ? w_b_hs : w_r_hs;
  // On contention the I side wins only if D was served last.
  assign w_pick_i = Irequest & (~Drequest | (r_last == LS_D));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_grant <= NO_GRANT;
      r_last  <= LS_D;
      r_d_wr  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_d_wr <= 1'b0;
          if (w_pick_i) begin
            r_state <= ST_OWN_I;
            r_grant <= INSTMEM_GRANT;
          end else if (Drequest) begin
            r_state <= ST_OWN_D;
            r_grant <= DATAMEM_GRANT;
          end
        end
        ST_OWN_I: begin
          if (w_r_hs) begin
            r_state <= ST_IDLE;
            r_grant <= NO_GRANT;
            r_last  <= LS_I;
          end
        end
        ST_OWN_D: begin
          if (w_aw_hs) r_d_wr <= 1'b1;
          if (w_d_done) begin
            r_state <= ST_IDLE;
            r_grant <= NO_GRANT;
            r_last  <= LS_D;
            r_d_wr  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= NO_GRANT;
        end
      endcase
    end
  end

  assign grant = r_grant;
  assign rdata = s_rdata;
  assign rresp = s_rresp;
  assign bresp = s_bresp;

  axi_grant_mux #(.DW(DATA_WIDTH)) u_mux (
    .grant     (r_grant),
    .i_araddr  (i_araddr),
    .i_arvalid (i_arvalid),
    .i_rready  (i_rready),
    .i_arready (i_arready),
    .i_rvalid  (i_rvalid),
    .d_araddr  (d_araddr),
    .d_arvalid (d_arvalid),
    .d_rready  (d_rready),
    .d_awaddr  (d_awaddr),
    .d_awvalid (d_awvalid),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_wvalid  (d_wvalid),
    .d_bready  (d_bready),
    .d_arready (d_arready),
    .d_rvalid  (d_rvalid),
    .d_awready (d_awready),
    .d_wready  (d_wready),
    .d_bvalid  (d_bvalid),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready)
  );

endmodule
